fifo_buffer_param: RTL and testbench

Parametrised synchronous FIFO for the SPI flash read path. It generalises the byte buffer to any width and any depth, including non-power-of-two depths. It adds almost-full/almost-empty thresholds, a live fill count, sticky overflow/underflow flags, synchronous flush, a first-word-fall-through (FWFT) mode and an overwrite-oldest mode. It sits between the SPI shifter (write side) and the host/UART drain logic (read side) in the same clock domain.

---
 rtl/fifo_buffer_param.sv | 146 ++++++++++++++
 tb/tb_fifo_buffer_param.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_buffer_param.sv
// Parametrised synchronous FIFO for the SPI flash read path.
// Supports any width and depth, including depths that are not a power of two.
// Features: almost-full/almost-empty thresholds, fill count, sticky error flags,
// synchronous flush, first-word-fall-through mode and overwrite-oldest mode.
module fifo_buffer_param #(
    parameter int unsigned W         = 8,
    parameter int unsigned D         = 256,
    parameter int unsigned AF_TH     = D - 4,
    parameter int unsigned AE_TH     = 4,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned OVERWRITE = 0,
    localparam int unsigned AW       = $clog2(D),
    localparam int unsigned CW       = $clog2(D + 1)
) (
    input  logic          system_clk,
    input  logic          system_reset_n,
    input  logic          write_req,
    input  logic [W-1:0]  fifo_dataIn,
    input  logic          read_req,
    output logic [W-1:0]  fifo_dataOut,
    output logic          data_valid,
    output logic          empty,
    output logic          full,
    output logic          almost_empty,
    output logic          almost_full,
    output logic [CW-1:0] fill_count,
    output logic          overflow,
    output logic          underflow,
    input  logic          flush,
    input  logic          clear_err
);

    localparam logic [AW-1:0] LAST_IDX = AW'(D - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(D);

    logic [W-1:0]  r_mem [D];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_unf;

    logic          w_empty;
    logic          w_full;
    logic          w_rd_acc;
    logic          w_wr_acc;
    logic          w_drop_oldest;
    logic          w_ovf_set;
    logic          w_unf_set;

    // Pointer increment with explicit wrap at D-1 so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + AW'(1);
    endfunction

    // Status flags depend only on the registered fill count.
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == FULL_CNT);
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (32'(r_count) <= AE_TH);
    assign almost_full  = (32'(r_count) >= AF_TH);
    assign fill_count   = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

    // Accept logic: a same-cycle read frees a slot for the write when full.
    assign w_rd_acc      = read_req && !w_empty;
    assign w_wr_acc      = write_req && (!w_full || w_rd_acc || (OVERWRITE != 0));
    assign w_drop_oldest = w_wr_acc && w_full && !w_rd_acc;
    assign w_ovf_set     = !flush && write_req && w_full && !w_rd_acc;
    assign w_unf_set     = !flush && read_req && w_empty;

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge system_clk) begin
        if (w_wr_acc && !flush) begin
            r_mem[r_wr_ptr] <= fifo_dataIn;
        end
    end

    // Pointers and fill count; flush overrides any same-cycle read or write.
    always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd_acc || w_drop_oldest) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_wr_acc && !w_rd_acc && !w_full) begin
                r_count <= r_count + CW'(1);
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Sticky error flags; a set event beats a same-cycle clear.
    always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set || (r_ovf && !clear_err);
            r_unf <= w_unf_set || (r_unf && !clear_err);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is always presented; valid whenever something is stored.
            assign fifo_dataOut = r_mem[r_rd_ptr];
            assign data_valid   = !w_empty;
        end else begin : g_reg
            logic [W-1:0] r_dout;
            logic         r_dv;

            // Registered read: data and a one-cycle valid pulse after each accepted pop.
            always_ff @(posedge system_clk or negedge system_reset_n) begin
                if (!system_reset_n) begin
                    r_dout <= '0;
                    r_dv   <= 1'b0;
                end else if (flush) begin
                    r_dv   <= 1'b0;
                end else begin
                    r_dv <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_dout <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign fifo_dataOut = r_dout;
            assign data_valid   = r_dv;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_buffer_param.sv
// Self-checking bench for fifo_buffer_param: four configurations share one
// stimulus bus; a scoreboard queue holds expected read data for the selected
// registered-read instance and a monitor pops it on every data_valid pulse.
module tb_fifo_buffer_param;

    logic       clk;
    logic       rst_n;
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic       fl;
    logic       ce;

    // Instance A: D=8, registered read, no overwrite
    logic [7:0] dout_a; logic dv_a, emp_a, full_a, ae_a, af_a, ovf_a, unf_a; logic [3:0] cnt_a;
    // Instance B: D=6, registered read
    logic [7:0] dout_b; logic dv_b, emp_b, full_b, ae_b, af_b, ovf_b, unf_b; logic [2:0] cnt_b;
    // Instance C: D=8, overwrite-oldest
    logic [7:0] dout_c; logic dv_c, emp_c, full_c, ae_c, af_c, ovf_c, unf_c; logic [3:0] cnt_c;
    // Instance D: D=8, first-word-fall-through
    logic [7:0] dout_d; logic dv_d, emp_d, full_d, ae_d, af_d, ovf_d, unf_d; logic [3:0] cnt_d;

    int         nvec;
    int         nfail;
    int         sel;
    logic [7:0] exp_q[$];

    fifo_buffer_param #(.W(8), .D(8), .AF_TH(4), .AE_TH(2), .FWFT(0), .OVERWRITE(0)) u_a (
        .system_clk(clk), .system_reset_n(rst_n), .write_req(wr), .fifo_dataIn(din),
        .read_req(rd), .fifo_dataOut(dout_a), .data_valid(dv_a), .empty(emp_a), .full(full_a),
        .almost_empty(ae_a), .almost_full(af_a), .fill_count(cnt_a), .overflow(ovf_a),
        .underflow(unf_a), .flush(fl), .clear_err(ce));

    fifo_buffer_param #(.W(8), .D(6), .AF_TH(4), .AE_TH(1), .FWFT(0), .OVERWRITE(0)) u_b (
        .system_clk(clk), .system_reset_n(rst_n), .write_req(wr), .fifo_dataIn(din),
        .read_req(rd), .fifo_dataOut(dout_b), .data_valid(dv_b), .empty(emp_b), .full(full_b),
        .almost_empty(ae_b), .almost_full(af_b), .fill_count(cnt_b), .overflow(ovf_b),
        .underflow(unf_b), .flush(fl), .clear_err(ce));

    fifo_buffer_param #(.W(8), .D(8), .AF_TH(4), .AE_TH(2), .FWFT(0), .OVERWRITE(1)) u_c (
        .system_clk(clk), .system_reset_n(rst_n), .write_req(wr), .fifo_dataIn(din),
        .read_req(rd), .fifo_dataOut(dout_c), .data_valid(dv_c), .empty(emp_c), .full(full_c),
        .almost_empty(ae_c), .almost_full(af_c), .fill_count(cnt_c), .overflow(ovf_c),
        .underflow(unf_c), .flush(fl), .clear_err(ce));

    fifo_buffer_param #(.W(8), .D(8), .AF_TH(4), .AE_TH(2), .FWFT(1), .OVERWRITE(0)) u_d (
        .system_clk(clk), .system_reset_n(rst_n), .write_req(wr), .fifo_dataIn(din),
        .read_req(rd), .fifo_dataOut(dout_d), .data_valid(dv_d), .empty(emp_d), .full(full_d),
        .almost_empty(ae_d), .almost_full(af_d), .fill_count(cnt_d), .overflow(ovf_d),
        .underflow(unf_d), .flush(fl), .clear_err(ce));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; inputs are stable across the rising edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic f, input logic c);
        wr = w; din = d; rd = r; fl = f; ce = c;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; fl = 1'b0; ce = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // Monitor: pop and compare on every read-data pulse of the selected instance.
    logic       m_v;
    logic [7:0] m_d;
    logic [7:0] m_e;
    always @(negedge clk) begin
        if (rst_n) begin
            case (sel)
                0: begin m_v = dv_a; m_d = dout_a; end
                1: begin m_v = dv_b; m_d = dout_b; end
                2: begin m_v = dv_c; m_d = dout_c; end
                default: begin m_v = 1'b0; m_d = 8'h00; end
            endcase
            if (m_v) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    nfail++;
                    $display("FAIL rd_data: unexpected output 0x%0h on inst %0d at %0t", m_d, sel, $time);
                end else begin
                    m_e = exp_q.pop_front();
                    if (m_d !== m_e) begin
                        nfail++;
                        $display("FAIL rd_data: got 0x%0h expected 0x%0h on inst %0d at %0t",
                                 m_d, m_e, sel, $time);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] wv;
        logic [7:0] rv;
        clk = 1'b0; rst_n = 1'b0; wr = 1'b0; din = 8'h00; rd = 1'b0; fl = 1'b0; ce = 1'b0;
        nvec = 0; nfail = 0; sel = 0;

        // Reset state across all configurations
        do_reset();
        chk("rst_empty_a", emp_a, 1); chk("rst_full_a", full_a, 0);
        chk("rst_ae_a", ae_a, 1);     chk("rst_af_a", af_a, 0);
        chk("rst_cnt_a", cnt_a, 0);   chk("rst_dv_a", dv_a, 0);
        chk("rst_dout_a", dout_a, 0); chk("rst_ovf_a", ovf_a, 0); chk("rst_unf_a", unf_a, 0);
        chk("rst_empty_b", emp_b, 1); chk("rst_full_b", full_b, 0); chk("rst_ae_b", ae_b, 1);
        chk("rst_af_b", af_b, 0);     chk("rst_ovf_b", ovf_b, 0);  chk("rst_unf_b", unf_b, 0);
        chk("rst_empty_c", emp_c, 1); chk("rst_full_c", full_c, 0); chk("rst_ae_c", ae_c, 1);
        chk("rst_af_c", af_c, 0);     chk("rst_ovf_c", ovf_c, 0);  chk("rst_unf_c", unf_c, 0);
        chk("rst_empty_d", emp_d, 1); chk("rst_full_d", full_d, 0); chk("rst_ae_d", ae_d, 1);
        chk("rst_af_d", af_d, 0);     chk("rst_dv_d", dv_d, 0);
        chk("rst_ovf_d", ovf_d, 0);   chk("rst_unf_d", unf_d, 0);

        // Fill D=8 with 0x01..0x08, then drain in order
        sel = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            chk("fill_cnt", cnt_a, i);
            chk("fill_af", af_a, (i >= 4) ? 1 : 0);
            chk("fill_ae", ae_a, (i <= 2) ? 1 : 0);
        end
        chk("fill_full", full_a, 1);
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(8'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_empty", emp_a, 1);
        chk("drain_full", full_a, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t1_queue", exp_q.size(), 0);

        // D=6: fill, then 20 simultaneous read+write cycles crossing the wrap
        sel = 1;
        do_reset();
        wv = 8'h20; rv = 8'h20;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, wv, 1'b0, 1'b0, 1'b0);
            wv++;
        end
        chk("d6_full", full_b, 1);
        chk("d6_cnt", cnt_b, 6);
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(rv); rv++;
            step(1'b1, wv, 1'b1, 1'b0, 1'b0);
            wv++;
            chk("d6_cnt_rw", cnt_b, 6);
        end
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(rv); rv++;
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        chk("d6_empty", emp_b, 1);
        chk("d6_ovf", ovf_b, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t2_queue", exp_q.size(), 0);

        // Full with OVERWRITE=0: dropped write, then read+write while full
        sel = 0;
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        chk("drop_ovf", ovf_a, 1);
        chk("drop_cnt", cnt_a, 8);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", ovf_a, 0);
        exp_q.push_back(8'h01);
        step(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);
        chk("rw_full_cnt", cnt_a, 8);
        chk("rw_full_ovf", ovf_a, 0);
        for (int i = 2; i <= 8; i++) begin
            exp_q.push_back(8'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        exp_q.push_back(8'hBB);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t3_queue", exp_q.size(), 0);

        // OVERWRITE=1: write while full replaces the oldest entry
        sel = 2;
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
        chk("ow_ovf", ovf_c, 1);
        chk("ow_cnt", cnt_c, 8);
        chk("ow_full", full_c, 1);
        for (int i = 2; i <= 9; i++) begin
            exp_q.push_back(8'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        chk("ow_empty", emp_c, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t4_queue", exp_q.size(), 0);

        // FWFT: head visible without a read, sticky underflow priority
        sel = 3;
        do_reset();
        chk("fwft_dv0", dv_d, 0);
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("fwft_dout", dout_d, 8'h5A);
        chk("fwft_dv1", dv_d, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("fwft_pop_empty", emp_d, 1);
        chk("fwft_pop_dv", dv_d, 0);
        chk("fwft_unf0", unf_d, 0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("fwft_unf1", unf_d, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("unf_set_wins", unf_d, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("unf_clear", unf_d, 0);
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        chk("fwft_head1", dout_d, 8'h11);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("fwft_head2", dout_d, 8'h22);
        chk("fwft_cnt", cnt_d, 1);

        // Flush drops a same-cycle write; async reset mid-burst
        sel = 0;
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        chk("pre_flush_cnt", cnt_a, 4);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        chk("flush_cnt", cnt_a, 0);
        chk("flush_empty", emp_a, 1);
        chk("flush_dv", dv_a, 0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("flush_unf", unf_a, 1);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(8'h33);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t6_queue", exp_q.size(), 0);
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(8'h41);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_dv", dv_a, 0);
        chk("async_dout", dout_a, 0);
        chk("async_cnt", cnt_a, 0);
        chk("async_empty", emp_a, 1);
        chk("async_unf", unf_a, 0);
        chk("async_ae", ae_a, 1);
        chk("t6b_queue", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
